// File: rtl/varidx_bit_writer.sv
// varidx_bit_writer: queues bit-write / word-load commands in a small FIFO
// and retires one per cycle into register q (q[idx] <= bit semantics).
// Optional feature macro: VARIDX_OOR_FLAG_EN -- when defined, a retired bit
// write whose index is outside q raises a sticky err flag; otherwise err is 0.
module varidx_bit_writer #(
  parameter int WIDTH = 4,
  parameter int IDXW  = 3,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_load,
  input  logic [IDXW-1:0]            in_idx,
  input  logic                       in_bit,
  input  logic [WIDTH-1:0]           in_word,
  output logic [WIDTH-1:0]           q,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // FIFO storage; payload is data and carries no reset
  logic             mem_load [DEPTH];
  logic [IDXW-1:0]  mem_idx  [DEPTH];
  logic             mem_bit  [DEPTH];
  logic [WIDTH-1:0] mem_word [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push, pop;

  logic             head_load;
  logic [IDXW-1:0]  head_idx;
  logic             head_bit;
  logic [WIDTH-1:0] head_word;
  logic             head_oor;

  // True when a bit index falls outside the target register
  function automatic logic idx_out_of_range(input logic [IDXW-1:0] idx);
    return int'(idx) >= WIDTH;
  endfunction

  // Next value of q after applying one command; out-of-range writes leave q intact
  function automatic logic [WIDTH-1:0] apply_cmd(
    input logic [WIDTH-1:0] cur,
    input logic             ld,
    input logic [IDXW-1:0]  idx,
    input logic             b,
    input logic [WIDTH-1:0] word
  );
    logic [WIDTH-1:0] mask;
    mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
    if (ld)
      return word;
    else if (idx_out_of_range(idx))
      return cur;
    else
      return b ? (cur | mask) : (cur & ~mask);
  endfunction

  assign in_ready = !rst && (cnt < DEPTH_C);
  assign push     = in_valid && in_ready;
  assign pop      = (cnt != '0);
  assign count    = cnt;
  assign busy     = (cnt != '0);

  assign head_load = mem_load[rd_ptr];
  assign head_idx  = mem_idx[rd_ptr];
  assign head_bit  = mem_bit[rd_ptr];
  assign head_word = mem_word[rd_ptr];
  assign head_oor  = !head_load && idx_out_of_range(head_idx);

  // Capture accepted command payload at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem_load[wr_ptr] <= in_load;
      mem_idx[wr_ptr]  <= in_idx;
      mem_bit[wr_ptr]  <= in_bit;
      mem_word[wr_ptr] <= in_word;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Retire the FIFO head into q once per cycle
  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (pop)
      q <= apply_cmd(q, head_load, head_idx, head_bit, head_word);
  end

`ifdef VARIDX_OOR_FLAG_EN
  logic err_r;

  // Sticky flag for a retired bit write that addressed beyond q
  always_ff @(posedge clk) begin
    if (rst)
      err_r <= 1'b0;
    else if (pop && head_oor)
      err_r <= 1'b1;
  end

  assign err = err_r;
`else
  logic unused_oor;
  assign unused_oor = head_oor;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_varidx_bit_writer.sv
// Testbench for varidx_bit_writer: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_varidx_bit_writer;

  localparam int WIDTH = 4;
  localparam int IDXW  = 3;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic             in_load;
  logic [IDXW-1:0]  in_idx;
  logic             in_bit;
  logic [WIDTH-1:0] in_word;
  logic [WIDTH-1:0] q;
  logic [$clog2(DEPTH):0] count;
  logic             busy;
  logic             err;

  varidx_bit_writer #(.WIDTH(WIDTH), .IDXW(IDXW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_load(in_load), .in_idx(in_idx), .in_bit(in_bit), .in_word(in_word),
    .q(q), .count(count), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             load;
    int             idx;
    bit             b;
    bit [WIDTH-1:0] word;
  } cmd_t;

  cmd_t           mq[$];
  bit [WIDTH-1:0] mq_q;
  bit             m_err;
  int             passed;
  int             total;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    assert (act === exp) passed++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
  endtask

  // One clock cycle: drive inputs, check ready, clock, update model, check outputs
  task automatic step(input logic r, input logic v, input logic ld,
                      input logic [IDXW-1:0] ix, input logic b,
                      input logic [WIDTH-1:0] w);
    bit   exp_ready;
    bit   acc;
    cmd_t c;
    rst = r; in_valid = v; in_load = ld; in_idx = ix; in_bit = b; in_word = w;
    #1;
    exp_ready = !r && (mq.size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mq_q  = '0;
      m_err = 1'b0;
    end else begin
      if (mq.size() > 0) begin
        c = mq.pop_front();
        if (c.load)
          mq_q = c.word;
        else if (c.idx < WIDTH)
          mq_q[c.idx] = c.b;
        else begin
`ifdef VARIDX_OOR_FLAG_EN
          m_err = 1'b1;
`endif
        end
      end
      if (acc) begin
        c.load = ld; c.idx = int'(ix); c.b = b; c.word = w;
        mq.push_back(c);
      end
    end
    check("q",     32'(q),     32'(mq_q));
    check("count", 32'(count), 32'(mq.size()));
    check("busy",  32'(busy),  32'(mq.size() != 0));
    check("err",   32'(err),   32'(m_err));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    passed = 0; total = 0;
    mq_q = '0; m_err = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_load = 1'b0; in_idx = '0; in_bit = 1'b0; in_word = '0;

    // Reset
    step(1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 4'b1010);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000);
    check("reset_q", 32'(q), 32'h0);
    check("reset_count", 32'(count), 32'h0);

    // Basic: load 1111, then clear bit 0, then bit 1
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 4'b1111);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000);
    check("basic_load", 32'(q), 32'hF);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 4'b0000);
    check("basic_bit0", 32'(q), 32'hE);
    idle(2);
    check("basic_bit1", 32'(q), 32'hC);

    // Fill: stream bit writes 0..3 with bit=1 after reset
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 3'(i), 1'b1, 4'b0000);
    idle(2);
    check("fill_q", 32'(q), 32'hF);

    // Backpressure: five back-to-back pushes right after reset
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0101);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 3'd3, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 4'b0000);
    idle(3);

    // Same-bit ordering: last write to bit 2 wins
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 3'd2, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 3'd2, 1'b0, 4'b0000);
    idle(2);
    check("same_bit_q2", 32'(q[2]), 32'h0);

    // Out-of-range write on q=0000
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 3'd5, 1'b1, 4'b0000);
    idle(2);
    check("oor_q", 32'(q), 32'h0);
`ifdef VARIDX_OOR_FLAG_EN
    check("oor_err", 32'(err), 32'h1);
`else
    check("oor_err", 32'(err), 32'h0);
`endif

    // Reset in the middle of a burst
    step(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 4'b1001);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 4'b0000);
    step(1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 4'b0000);
    check("midrst_count", 32'(count), 32'h0);
    check("midrst_q", 32'(q), 32'h0);
    idle(3);
    check("midrst_q_after", 32'(q), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0),
           3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           4'($urandom));
    end
    idle(6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
